// File: rtl/uart_tx16_if.sv
// ---------------------------------------------------------------------------
// uart_tx16_if
// Purpose : groups the load handshake and serial outputs of uart_tx16.
// Signals : I     [15:0] word to transmit (master -> slave)
//           En           load request     (master -> slave)
//           Ready        idle / can accept a word (slave -> master)
//           TX           serial line, idle high   (slave -> master)
//           Done         one-cycle end-of-word pulse (slave -> master)
// ---------------------------------------------------------------------------
interface uart_tx16_if;
  logic [15:0] I;
  logic        En;
  logic        Ready;
  logic        TX;
  logic        Done;

  modport master (output I, output En, input Ready, input TX, input Done);
  modport slave  (input I, input En, output Ready, output TX, output Done);
endinterface

// File: rtl/uart_tx16.sv
// ---------------------------------------------------------------------------
// uart_tx16
// Purpose : sends one 16-bit word as two UART frames (low byte first) on a
//           single line, with a Ready/En load handshake and a Done pulse.
// Ports   : CLK    system clock, rising edge
//           CLR_n  asynchronous active-low reset
//           bus    uart_tx16_if.slave (I, En in; Ready, TX, Done out)
// Params  : CLK_DIV  clock cycles per serial bit (2..65535)
// Options : define UART_TX16_PARITY_EN to insert an even-parity bit after
//           data bit 7 of each byte (8E1 framing instead of 8N1).
// ---------------------------------------------------------------------------
module uart_tx16 #(
  parameter int CLK_DIV = 16
) (
  input  logic         CLK,
  input  logic         CLR_n,
  uart_tx16_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_TX16_PARITY_EN
    S_PAR   = 3'd4,
`endif
    S_STOP  = 3'd3
  } state_t;

  localparam logic [15:0] LP_TMAX = 16'(CLK_DIV - 1);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic        r_bsel;
  logic [15:0] r_hold;
  logic        r_tx;
  logic        r_ready;
  logic        r_done;

  state_t      w_state_nxt;
  logic [15:0] w_timer_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_bsel_nxt;
  logic [15:0] w_hold_nxt;
  logic        w_tx_nxt;
  logic        w_ready_nxt;
  logic        w_done_nxt;
  logic        w_bit_end;
  logic [7:0]  w_byte_nxt;

  // Even-parity helper: XOR of all data bits of one byte.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  assign w_bit_end = (r_timer == LP_TMAX);

  // Next-state, bit timer and handshake flag logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_bit_end ? 16'd0 : (r_timer + 16'd1);
    w_idx_nxt   = r_idx;
    w_bsel_nxt  = r_bsel;
    w_hold_nxt  = r_hold;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = 16'd0;
        if (bus.En) begin
          w_hold_nxt  = bus.I;
          w_bsel_nxt  = 1'b0;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_START;
          w_ready_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
`ifdef UART_TX16_PARITY_EN
            w_state_nxt = S_PAR;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_TX16_PARITY_EN
      S_PAR: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PAR;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (!r_bsel) begin
            // High byte follows immediately, no idle gap.
            w_bsel_nxt  = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 16'd0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Line level for the coming cycle, derived from next state so TX is a flop.
  always_comb begin
    w_byte_nxt = w_bsel_nxt ? w_hold_nxt[15:8] : w_hold_nxt[7:0];
    w_tx_nxt   = 1'b1;
    case (w_state_nxt)
      S_IDLE:  w_tx_nxt = 1'b1;
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_byte_nxt[w_idx_nxt];
`ifdef UART_TX16_PARITY_EN
      S_PAR:   w_tx_nxt = even_parity(w_byte_nxt);
`endif
      S_STOP:  w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line to mark at once.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= S_IDLE;
      r_timer <= 16'd0;
      r_idx   <= 3'd0;
      r_bsel  <= 1'b0;
      r_hold  <= 16'd0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_bsel  <= w_bsel_nxt;
      r_hold  <= w_hold_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.TX    = r_tx;
  assign bus.Ready = r_ready;
  assign bus.Done  = r_done;

endmodule

// File: tb/tb_uart_tx16.sv
// ---------------------------------------------------------------------------
// tb_uart_tx16
// Purpose : self-checking bench for uart_tx16 with CLK_DIV=4. Inputs are
//           driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx16;

  localparam int DIV = 4;
`ifdef UART_TX16_PARITY_EN
  localparam int SEG = 11;
`else
  localparam int SEG = 10;
`endif
  localparam int NB  = 2 * SEG;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;
  int   done_cnt;

  uart_tx16_if u_bus ();

  uart_tx16 #(.CLK_DIV(DIV)) u_dut (
    .CLK   (clk),
    .CLR_n (clr_n),
    .bus   (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_bus.Done === 1'b1) done_cnt = done_cnt + 1;
  end

  typedef struct {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        plo;
    logic        phi;
    int          ign;
    bit          chain;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected line level for bit b (0..NB-1) of a word's frame pair.
  function automatic logic exp_bit(input int b, input logic [7:0] lo, input logic [7:0] hi,
                                   input logic plo, input logic phi);
    int   pos;
    logic [7:0] byt;
    logic par;
    pos = b % SEG;
    byt = (b < SEG) ? lo : hi;
    par = (b < SEG) ? plo : phi;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return byt[pos-1];
    if (SEG == 11 && pos == 9) return par;
    return 1'b1;
  endfunction

  // Called at a falling edge with the DUT idle; loads the word and checks
  // every cycle of the frame pair plus the Done/Ready cycle.
  task automatic run_word(input vec_t v);
    int  bi;
    u_bus.En = 1'b1;
    u_bus.I  = v.word;
    for (int k = 1; k <= NB * DIV; k++) begin
      @(negedge clk);
      if (k == 1 && !v.chain) u_bus.En = 1'b0;
      bi = (k - 1) / DIV;
      chk("tx_bit", {31'd0, u_bus.TX}, {31'd0, exp_bit(bi, v.lo, v.hi, v.plo, v.phi)});
      chk("ready_busy", {31'd0, u_bus.Ready}, 32'd0);
      chk("done_busy", {31'd0, u_bus.Done}, 32'd0);
      if (v.ign != 0 && k == v.ign) begin
        u_bus.En = 1'b1;
        u_bus.I  = 16'hFFFF;
      end
      if (v.ign != 0 && k == v.ign + 1) u_bus.En = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, u_bus.Done}, 32'd1);
    chk("ready_rise", {31'd0, u_bus.Ready}, 32'd1);
    chk("tx_idle_end", {31'd0, u_bus.TX}, 32'd1);
    if (!v.chain) begin
      @(negedge clk);
      chk("done_once", {31'd0, u_bus.Done}, 32'd0);
      chk("ready_hold", {31'd0, u_bus.Ready}, 32'd1);
    end
  endtask

  initial begin
    vec_t vecs [5];
    vec_t fresh;
    int   rc [2];
    int   d0;
    logic tx_before;

    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    d0       = 0;
    rc[0]    = 37;
    rc[1]    = 42;

    vecs[0] = '{word: 16'hA53C, lo: 8'h3C, hi: 8'hA5, plo: 1'b0, phi: 1'b0, ign: 0,  chain: 1'b0};
    vecs[1] = '{word: 16'h1234, lo: 8'h34, hi: 8'h12, plo: 1'b1, phi: 1'b0, ign: 30, chain: 1'b0};
    vecs[2] = '{word: 16'h00FF, lo: 8'hFF, hi: 8'h00, plo: 1'b0, phi: 1'b0, ign: 0,  chain: 1'b1};
    vecs[3] = '{word: 16'hFF00, lo: 8'h00, hi: 8'hFF, plo: 1'b0, phi: 1'b0, ign: 0,  chain: 1'b0};
    vecs[4] = '{word: 16'h0107, lo: 8'h07, hi: 8'h01, plo: 1'b1, phi: 1'b1, ign: 0,  chain: 1'b0};

    // Reset and idle hold.
    clr_n    = 1'b0;
    u_bus.En = 1'b0;
    u_bus.I  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, u_bus.TX}, 32'd1);
    chk("rst_ready", {31'd0, u_bus.Ready}, 32'd1);
    chk("rst_done", {31'd0, u_bus.Done}, 32'd0);
    clr_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_tx", {31'd0, u_bus.TX}, 32'd1);
      chk("idle_ready", {31'd0, u_bus.Ready}, 32'd1);
      chk("idle_done", {31'd0, u_bus.Done}, 32'd0);
    end

    // Table of words: normal, ignored En mid-word, back-to-back pair, parity case.
    for (int v = 0; v < 5; v++) begin
      if (v == 2) d0 = done_cnt;
      run_word(vecs[v]);
      if (v == 3) chk("b2b_done_count", done_cnt - d0, 32'd2);
    end

    // Reset in the middle of a word, then a fresh word.
    for (int r = 0; r < 2; r++) begin
      u_bus.En = 1'b1;
      u_bus.I  = 16'h1234;
      for (int k = 1; k <= rc[r]; k++) begin
        @(negedge clk);
        u_bus.En = 1'b0;
      end
      tx_before = u_bus.TX;
      chk("pre_rst_tx", {31'd0, tx_before},
          {31'd0, exp_bit((rc[r] - 1) / DIV, 8'h34, 8'h12, 1'b1, 1'b0)});
      chk("pre_rst_ready", {31'd0, u_bus.Ready}, 32'd0);
      clr_n = 1'b0;
      #1;
      chk("async_rst_tx", {31'd0, u_bus.TX}, 32'd1);
      chk("async_rst_ready", {31'd0, u_bus.Ready}, 32'd1);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_ready", {31'd0, u_bus.Ready}, 32'd1);
      chk("post_rst_tx", {31'd0, u_bus.TX}, 32'd1);
    end
    fresh = '{word: 16'h0001, lo: 8'h01, hi: 8'h00, plo: 1'b1, phi: 1'b0, ign: 0, chain: 1'b0};
    run_word(fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
